// File: rtl/mips_pkg.sv
// Shared definitions for the MEM stage: access-size codes, FSM states,
// byte-enable patterns and the alignment rule.
package mips_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } access_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DONE = 2'b10
  } mau_state_e;

  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  // Bytes are always aligned; halves need bit 0 clear; word and the
  // reserved code need both low bits clear.
  function automatic logic addr_aligned(input logic [1:0] size, input logic [1:0] lo);
    logic ok;
    case (size)
      SIZE_BYTE: ok = 1'b1;
      SIZE_HALF: ok = ~lo[0];
      default:   ok = (lo == 2'b00);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_store_align.sv
// Combinational lane logic: byte enables, store-data replication and
// load-data lane extraction with sign/zero extension.
module load_store_align
  import mips_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        signed_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  byte_en_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o
);

  logic [7:0]  byte_lane_s;
  logic [15:0] half_lane_s;

  // Pick the addressed lanes out of the returned word.
  always_comb begin
    byte_lane_s = rdata_i[{addr_lo_i, 3'b000} +: 8];
    half_lane_s = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  // Size-dependent enables, store replication and load extension.
  always_comb begin
    byte_en_o   = BE_WORD;
    wdata_o     = store_data_i;
    load_data_o = rdata_i;
    case (size_i)
      SIZE_BYTE: begin
        byte_en_o   = BE_BYTE0 << addr_lo_i;
        wdata_o     = {4{store_data_i[7:0]}};
        load_data_o = signed_i ? {{24{byte_lane_s[7]}}, byte_lane_s}
                               : {24'h000000, byte_lane_s};
      end
      SIZE_HALF: begin
        byte_en_o   = addr_lo_i[1] ? BE_HALF_HI : BE_HALF_LO;
        wdata_o     = {2{store_data_i[15:0]}};
        load_data_o = signed_i ? {{16{half_lane_s[15]}}, half_lane_s}
                               : {16'h0000, half_lane_s};
      end
      default: begin
        byte_en_o   = BE_WORD;
        wdata_o     = store_data_i;
        load_data_o = rdata_i;
      end
    endcase
  end

endmodule

// File: rtl/memory_access_unit.sv
// MEM pipeline stage: issues loads/stores over a req/ack data bus, stalls
// upstream while an access is outstanding, formats load data, and registers
// the writeback and branch results.
module memory_access_unit
  import mips_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ADDR_WIDTH     = 32
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  ValidIn,
  input  logic                  BranchIn,
  input  logic                  MemReadIn,
  input  logic                  MemWriteIn,
  input  logic                  RegWriteIn,
  input  logic                  MemToRegIn,
  input  logic [1:0]            AccessSizeIn,
  input  logic                  SignedLoadIn,
  input  logic [31:0]           ALUResultIn,
  input  logic                  ZeroIn,
  input  logic [31:0]           BranchTargetIn,
  input  logic [31:0]           StoreDataIn,
  input  logic [4:0]            DestRegIn,
  output logic                  StallOut,
  output logic                  PCSrcOut,
  output logic [31:0]           BranchTargetOut,
  output logic                  MemReq,
  output logic                  MemWe,
  output logic [ADDR_WIDTH-1:0] MemAddr,
  output logic [31:0]           MemWData,
  output logic [3:0]            MemByteEn,
  input  logic                  MemAck,
  input  logic [31:0]           MemRData,
  output logic                  ValidOut,
  output logic                  RegWriteOut,
  output logic [31:0]           WriteDataOut,
  output logic [4:0]            DestRegOut,
  output logic                  MisalignedOut,
  output logic                  BusErrorOut
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  mau_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Instruction latched for the duration of a memory access.
  logic [31:0] alu_q, alu_d, store_q, store_d, target_q, target_d;
  logic [4:0]  dest_q, dest_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d, we_q, we_d, mtr_q, mtr_d;
  logic        rw_q, rw_d, take_q, take_d;

  // Writeback output registers.
  logic        valid_q, valid_d, regwr_q, regwr_d, pcsrc_q, pcsrc_d;
  logic        mis_q, mis_d, berr_q, berr_d;
  logic [31:0] wdata_q, wdata_d, btgt_q, btgt_d;
  logic [4:0]  wdest_q, wdest_d;

  logic        mem_op_s, aligned_s;
  logic [3:0]  be_s;
  logic [31:0] mwdata_s, load_s;

  load_store_align u_align (
    .size_i       (size_q),
    .addr_lo_i    (alu_q[1:0]),
    .signed_i     (signed_q),
    .store_data_i (store_q),
    .rdata_i      (MemRData),
    .byte_en_o    (be_s),
    .wdata_o      (mwdata_s),
    .load_data_o  (load_s)
  );

  // Classify the incoming instruction and drive the upstream stall.
  always_comb begin
    mem_op_s  = MemReadIn | MemWriteIn;
    aligned_s = addr_aligned(AccessSizeIn, ALUResultIn[1:0]);
    if (state_q == ST_IDLE) begin
      StallOut = ValidIn & mem_op_s & aligned_s;
    end else begin
      StallOut = 1'b1;
    end
  end

  // Bus signals are driven only while waiting for the acknowledge.
  always_comb begin
    if (state_q == ST_WAIT) begin
      MemReq    = 1'b1;
      MemWe     = we_q;
      MemAddr   = {alu_q[ADDR_WIDTH-1:2], 2'b00};
      MemWData  = mwdata_s;
      MemByteEn = be_s;
    end else begin
      MemReq    = 1'b0;
      MemWe     = 1'b0;
      MemAddr   = '0;
      MemWData  = 32'h0;
      MemByteEn = 4'b0000;
    end
  end

  // Next-state, latch and writeback logic; outputs default to a bubble.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    alu_d    = alu_q;    store_d  = store_q;  target_d = target_q;
    dest_d   = dest_q;   size_d   = size_q;   signed_d = signed_q;
    we_d     = we_q;     mtr_d    = mtr_q;    rw_d     = rw_q;
    take_d   = take_q;
    valid_d  = 1'b0;     regwr_d  = 1'b0;     pcsrc_d  = 1'b0;
    mis_d    = 1'b0;     berr_d   = 1'b0;
    wdata_d  = 32'h0;    btgt_d   = 32'h0;    wdest_d  = 5'd0;
    case (state_q)
      ST_IDLE: begin
        if (ValidIn) begin
          if (mem_op_s && aligned_s) begin
            alu_d    = ALUResultIn;  store_d = StoreDataIn;
            target_d = BranchTargetIn; dest_d = DestRegIn;
            size_d   = AccessSizeIn; signed_d = SignedLoadIn;
            we_d     = MemWriteIn;   mtr_d   = MemToRegIn;
            rw_d     = RegWriteIn & ~MemWriteIn;
            take_d   = BranchIn & ZeroIn;
            cnt_d    = '0;
            state_d  = ST_WAIT;
          end else begin
            valid_d  = 1'b1;
            wdata_d  = ALUResultIn;
            wdest_d  = DestRegIn;
            btgt_d   = BranchTargetIn;
            pcsrc_d  = BranchIn & ZeroIn;
            mis_d    = mem_op_s;
            regwr_d  = RegWriteIn & ~mem_op_s;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (MemAck || (cnt_q == CNT_LAST)) begin
          state_d = ST_DONE;
          valid_d = 1'b1;
          wdest_d = dest_q;
          btgt_d  = target_q;
          pcsrc_d = take_q;
          berr_d  = ~MemAck;
          regwr_d = rw_q & MemAck;
          wdata_d = (MemAck && mtr_q && !we_q) ? load_s : alu_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, latch and output registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;  cnt_q <= '0;
      alu_q <= 32'h0;      store_q <= 32'h0;   target_q <= 32'h0;
      dest_q <= 5'd0;      size_q <= 2'b00;    signed_q <= 1'b0;
      we_q <= 1'b0;        mtr_q <= 1'b0;      rw_q <= 1'b0;
      take_q <= 1'b0;
      valid_q <= 1'b0;     regwr_q <= 1'b0;    pcsrc_q <= 1'b0;
      mis_q <= 1'b0;       berr_q <= 1'b0;
      wdata_q <= 32'h0;    btgt_q <= 32'h0;    wdest_q <= 5'd0;
    end else begin
      state_q <= state_d;  cnt_q <= cnt_d;
      alu_q <= alu_d;      store_q <= store_d; target_q <= target_d;
      dest_q <= dest_d;    size_q <= size_d;   signed_q <= signed_d;
      we_q <= we_d;        mtr_q <= mtr_d;     rw_q <= rw_d;
      take_q <= take_d;
      valid_q <= valid_d;  regwr_q <= regwr_d; pcsrc_q <= pcsrc_d;
      mis_q <= mis_d;      berr_q <= berr_d;
      wdata_q <= wdata_d;  btgt_q <= btgt_d;   wdest_q <= wdest_d;
    end
  end

  assign ValidOut        = valid_q;
  assign RegWriteOut     = regwr_q;
  assign PCSrcOut        = pcsrc_q;
  assign MisalignedOut   = mis_q;
  assign BusErrorOut     = berr_q;
  assign WriteDataOut    = wdata_q;
  assign BranchTargetOut = btgt_q;
  assign DestRegOut      = wdest_q;

endmodule
